arbitro_memoria: RTL and testbench
==================================

Name: arbitro_memoria

Overview:
- Two-requester arbiter and sequencer for the single shared synchronous-read word memory.
- Requester 0 is the processor's ADDR/DOUT/W_D path; requester 1 is the program loader / debug port.
- Serialises accesses, drives the memory address/data/write-enable, and returns read data with a one-cycle Ack pulse.
- Sits between the processor datapath and the memory.

Parameters:
- ADDR_W, 7, memory word-address width.
- DATA_W, 16, data word width (matches the processor bus).
- MEM_LAT, 1, memory read latency in clock edges from address-register load to valid mem_rdata; legal range 1..3.

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- Req0  in  1  requester 0 access request.
- We0  in  1  requester 0 write (1) / read (0).
- Addr0  in  ADDR_W  requester 0 address.
- Wdata0  in  DATA_W  requester 0 write data.
- Req1  in  1  requester 1 access request.
- We1  in  1  requester 1 write (1) / read (0).
- Addr1  in  ADDR_W  requester 1 address.
- Wdata1  in  DATA_W  requester 1 write data.
- Gnt  out  2  one-hot grant: bit0 = requester 0, bit1 = requester 1.
- Ack  out  2  one-cycle completion pulse per requester.
- Rdata  out  DATA_W  read data, valid in the Ack cycle.
- Busy  out  1  high whenever state is not IDLE.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_we  out  1  memory write strobe.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- All outputs are registered.
- Reset (Resetn=0, asynchronous):
  - State IDLE; Gnt=0, Ack=0, Rdata=0, Busy=0.
  - mem_addr=0, mem_wdata=0, mem_we=0.
  - Round-robin pointer = 0 (requester 0 favoured).
  - Wait counter = 0.
  - Reset mid-transaction aborts it; no Ack is ever issued for the aborted access.
- States: IDLE -> ACCESS -> WAIT -> RESP -> IDLE.
- IDLE:
  - No Req: stay in IDLE, all strobes 0.
  - Any Req: pick a winner, latch its Addr/Wdata/We into mem_addr/mem_wdata/mem_we, set its Gnt bit, go to ACCESS.
- Arbitration:
  - Only one requester: it wins.
  - Both requesting: the one not served last wins (round-robin).
  - The pointer updates at grant time.
- ACCESS (1 cycle):
  - Memory samples mem_addr/mem_wdata/mem_we.
  - On leaving ACCESS, mem_we drops to 0; mem_we is never high for more than one cycle per transaction.
  - Counter loads MEM_LAT-1; go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - When the counter is 0, capture mem_rdata into Rdata (reads only; Rdata holds its previous value on writes), set the Ack bit, go to RESP.
- RESP (1 cycle):
  - Ack bit high, Gnt bit still high.
  - On exit: Gnt=0, Ack=0, go to IDLE.
- Latency: Ack high exactly MEM_LAT+2 edges after the IDLE edge that sampled Req. Minimum 3 edges at MEM_LAT=1; back-to-back transaction period MEM_LAT+3.
- Held for the whole grant: mem_addr and Gnt.
- Requester rules:
  - Hold Req, Addr, We and Wdata stable until its Ack.
  - Req still high in the cycle after Ack is a new request.
  - Req dropped before Ack: the transaction still completes and Ack still pulses.
- Request changes while Busy are ignored until IDLE.
- Gnt and Ack are never both-bits-high.
- Gnt is 0 in IDLE.

Optional Feature:
- Macro ARB_MEM_PRIO_FIXA_EN.
- Defined: fixed priority; requester 0 always wins a simultaneous request, the pointer is not implemented, and requester 1 can starve.
- Undefined: round-robin as specified above.

Test Plan:
- Reset check: Resetn=0 asserted while in WAIT -> all outputs 0 immediately; state IDLE; no Ack after release.
- Single read: Req0=1, We0=0, Addr0=7'h05, memory word 5 = 16'h00A7, MEM_LAT=1 -> Gnt=01 from the next edge; Ack=01 for one cycle on the 3rd edge; Rdata=16'h00A7; mem_we stays 0.
- Single write: Req1=1, We1=1, Addr1=7'h10, Wdata1=16'h1234 -> mem_we=1 for exactly one cycle; Ack=10; a following read of 7'h10 returns 16'h1234; Rdata unchanged by the write.
- Contention: Req0 and Req1 both held high for 4 transactions -> grant order 0,1,0,1. With ARB_MEM_PRIO_FIXA_EN -> order 0,0,0,0.
- Latency sweep: MEM_LAT=3 read of address 0 -> Ack exactly 5 edges after the Req sample; Busy high for 5 cycles.
- Early drop: Req0 deasserted in the ACCESS cycle -> Ack=01 still pulses; arbiter returns to IDLE; no second grant.

Source files
------------

// File: rtl/arbitro_memoria.sv
// ============================================================================
// arbitro_memoria : two-requester arbiter/sequencer for the shared word memory
// Optional macro ARB_MEM_PRIO_FIXA_EN selects fixed priority (requester 0).
// Revision 1.0
// ============================================================================
`default_nettype none

module arbitro_memoria #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Req0,
  input  logic              We0,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [DATA_W-1:0] Wdata0,
  input  logic              Req1,
  input  logic              We1,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [DATA_W-1:0] Wdata1,
  output logic [1:0]        Gnt,
  output logic [1:0]        Ack,
  output logic [DATA_W-1:0] Rdata,
  output logic              Busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [1:0] CNT_LOAD = 2'(MEM_LAT - 1);

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        cnt;
  logic [1:0]        cnt_nxt;
  logic              txn_we;
  logic              txn_we_nxt;
  logic [1:0]        gnt_nxt;
  logic [1:0]        ack_nxt;
  logic [DATA_W-1:0] rdata_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wdata_nxt;
  logic              we_nxt;
  logic              win;

`ifdef ARB_MEM_PRIO_FIXA_EN
  always_comb win = ~Req0;
`else
  // ptr names the requester favoured on a tie; it flips away from each winner.
  logic ptr;

  always_comb win = (Req0 & Req1) ? ptr : Req1;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      ptr <= 1'b0;
    end else if (state == ST_IDLE && (Req0 | Req1)) begin
      ptr <= ~win;
    end
  end
`endif

  always_comb begin
    state_nxt  = state;
    gnt_nxt    = Gnt;
    ack_nxt    = 2'b00;
    rdata_nxt  = Rdata;
    addr_nxt   = mem_addr;
    wdata_nxt  = mem_wdata;
    we_nxt     = 1'b0;
    cnt_nxt    = cnt;
    txn_we_nxt = txn_we;
    case (state)
      ST_IDLE: begin
        gnt_nxt = 2'b00;
        if (Req0 | Req1) begin
          state_nxt = ST_ACCESS;
          if (win) begin
            gnt_nxt    = 2'b10;
            addr_nxt   = Addr1;
            wdata_nxt  = Wdata1;
            we_nxt     = We1;
            txn_we_nxt = We1;
          end else begin
            gnt_nxt    = 2'b01;
            addr_nxt   = Addr0;
            wdata_nxt  = Wdata0;
            we_nxt     = We0;
            txn_we_nxt = We0;
          end
        end
      end
      ST_ACCESS: begin
        cnt_nxt   = CNT_LOAD;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt == 2'd0) begin
          // Writes leave the last read result visible on Rdata.
          if (!txn_we) begin
            rdata_nxt = mem_rdata;
          end
          ack_nxt   = Gnt;
          state_nxt = ST_RESP;
        end else begin
          cnt_nxt = cnt - 2'd1;
        end
      end
      ST_RESP: begin
        gnt_nxt   = 2'b00;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state     <= ST_IDLE;
      cnt       <= 2'd0;
      txn_we    <= 1'b0;
      Gnt       <= 2'b00;
      Ack       <= 2'b00;
      Rdata     <= '0;
      Busy      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      txn_we    <= txn_we_nxt;
      Gnt       <= gnt_nxt;
      Ack       <= ack_nxt;
      Rdata     <= rdata_nxt;
      Busy      <= (state_nxt != ST_IDLE);
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      mem_we    <= we_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_arbitro_memoria.sv
// ============================================================================
// tb_arbitro_memoria : directed bench, one DUT at MEM_LAT=1 and one at MEM_LAT=3
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_arbitro_memoria;

  localparam int AW = 7;
  localparam int DW = 16;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic Resetn;
  logic load_mem;

  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [1:0]    gnt, ack;
  logic [DW-1:0] rdata, mwdata, mrdata;
  logic          busy, mwe;
  logic [AW-1:0] maddr;

  logic          req0_b, we0_b, req1_b, we1_b;
  logic [AW-1:0] addr0_b, addr1_b;
  logic [DW-1:0] wdata0_b, wdata1_b;
  logic [1:0]    gnt_b, ack_b;
  logic [DW-1:0] rdata_b, mwdata_b, mrdata_b;
  logic          busy_b, mwe_b;
  logic [AW-1:0] maddr_b;

  logic [DW-1:0] mem_a [0:127];
  logic [DW-1:0] mem_b [0:127];
  logic [DW-1:0] rd_a;
  logic [DW-1:0] p0_b, p1_b, p2_b;

  int checks = 0;
  int errors = 0;
  int ack_n;
  int busy_cnt;
  logic [1:0]    ack_val;
  logic [DW-1:0] rd_seen;
  logic [1:0]    exp_order [0:3];

  arbitro_memoria #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut (
    .Clock(Clock), .Resetn(Resetn),
    .Req0(req0), .We0(we0), .Addr0(addr0), .Wdata0(wdata0),
    .Req1(req1), .We1(we1), .Addr1(addr1), .Wdata1(wdata1),
    .Gnt(gnt), .Ack(ack), .Rdata(rdata), .Busy(busy),
    .mem_addr(maddr), .mem_wdata(mwdata), .mem_we(mwe), .mem_rdata(mrdata)
  );

  arbitro_memoria #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) dut_b (
    .Clock(Clock), .Resetn(Resetn),
    .Req0(req0_b), .We0(we0_b), .Addr0(addr0_b), .Wdata0(wdata0_b),
    .Req1(req1_b), .We1(we1_b), .Addr1(addr1_b), .Wdata1(wdata1_b),
    .Gnt(gnt_b), .Ack(ack_b), .Rdata(rdata_b), .Busy(busy_b),
    .mem_addr(maddr_b), .mem_wdata(mwdata_b), .mem_we(mwe_b), .mem_rdata(mrdata_b)
  );

  // Synchronous-read memories: one registered stage, and a three-stage pipe.
  always @(posedge Clock) begin
    if (load_mem) begin
      for (int i = 0; i < 128; i++) mem_a[i] <= '0;
      mem_a[5] <= 16'h00A7;
    end else if (mwe) begin
      mem_a[maddr] <= mwdata;
    end
    rd_a <= mem_a[maddr];
  end
  assign mrdata = rd_a;

  always @(posedge Clock) begin
    if (load_mem) begin
      for (int i = 0; i < 128; i++) mem_b[i] <= '0;
      mem_b[0] <= 16'hBEEF;
    end else if (mwe_b) begin
      mem_b[maddr_b] <= mwdata_b;
    end
    p0_b <= mem_b[maddr_b];
    p1_b <= p0_b;
    p2_b <= p1_b;
  end
  assign mrdata_b = p2_b;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef ARB_MEM_PRIO_FIXA_EN
    exp_order[0] = 2'b01; exp_order[1] = 2'b01; exp_order[2] = 2'b01; exp_order[3] = 2'b01;
`else
    exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01; exp_order[3] = 2'b10;
`endif
    Resetn = 1'b0; load_mem = 1'b1;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    req0_b = 0; we0_b = 0; addr0_b = '0; wdata0_b = '0;
    req1_b = 0; we1_b = 0; addr1_b = '0; wdata1_b = '0;
    step(); step();
    load_mem = 1'b0;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_maddr", 32'(maddr), 32'h0);
    chk("rst_mwe", 32'(mwe), 32'h0);
    Resetn = 1'b1;
    step();

    // Single read by requester 0
    req0 = 1; we0 = 0; addr0 = 7'h05;
    step();
    chk("rd_gnt_e1", 32'(gnt), 32'h1);
    chk("rd_busy_e1", 32'(busy), 32'h1);
    chk("rd_maddr", 32'(maddr), 32'h05);
    chk("rd_mwe", 32'(mwe), 32'h0);
    step();
    chk("rd_ack_e2", 32'(ack), 32'h0);
    step();
    chk("rd_ack_e3", 32'(ack), 32'h1);
    chk("rd_rdata", 32'(rdata), 32'h00A7);
    chk("rd_gnt_resp", 32'(gnt), 32'h1);
    req0 = 0;
    step();
    chk("rd_ack_off", 32'(ack), 32'h0);
    chk("rd_gnt_off", 32'(gnt), 32'h0);
    chk("rd_busy_off", 32'(busy), 32'h0);
    step();

    // Single write by requester 1
    req1 = 1; we1 = 1; addr1 = 7'h10; wdata1 = 16'h1234;
    step();
    chk("wr_gnt", 32'(gnt), 32'h2);
    chk("wr_mwe_on", 32'(mwe), 32'h1);
    chk("wr_mwdata", 32'(mwdata), 32'h1234);
    chk("wr_maddr", 32'(maddr), 32'h10);
    step();
    chk("wr_mwe_off", 32'(mwe), 32'h0);
    step();
    chk("wr_ack", 32'(ack), 32'h2);
    chk("wr_rdata_hold", 32'(rdata), 32'h00A7);
    chk("wr_mwe_resp", 32'(mwe), 32'h0);
    req1 = 0; we1 = 0;
    step();
    req0 = 1; we0 = 0; addr0 = 7'h10;
    step(); step(); step();
    chk("rb_ack", 32'(ack), 32'h1);
    chk("rb_rdata", 32'(rdata), 32'h1234);
    req0 = 0;
    step();

    // Asynchronous reset while in WAIT
    req1 = 1; we1 = 0; addr1 = 7'h05;
    step(); step();
    chk("rs_busy_wait", 32'(busy), 32'h1);
    Resetn = 1'b0;
    #1;
    chk("rs_gnt", 32'(gnt), 32'h0);
    chk("rs_ack", 32'(ack), 32'h0);
    chk("rs_busy", 32'(busy), 32'h0);
    chk("rs_rdata", 32'(rdata), 32'h0);
    chk("rs_maddr", 32'(maddr), 32'h0);
    req1 = 0;
    step();
    Resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rs_no_ack", 32'(ack), 32'h0);
      chk("rs_no_gnt", 32'(gnt), 32'h0);
    end

    // Contention: both requesters held for four transactions
    req0 = 1; we0 = 0; addr0 = 7'h05;
    req1 = 1; we1 = 0; addr1 = 7'h10;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("ct_gnt", 32'(gnt), 32'(exp_order[k]));
      step(); step();
      chk("ct_ack", 32'(ack), 32'(exp_order[k]));
      chk("ct_rdata", 32'(rdata), (exp_order[k] == 2'b01) ? 32'h00A7 : 32'h1234);
      step();
      chk("ct_idle_gnt", 32'(gnt), 32'h0);
    end
    req0 = 0; req1 = 0;
    step();

    // Latency sweep on the MEM_LAT=3 instance
    ack_n = 0; busy_cnt = 0; ack_val = 2'b00; rd_seen = '0;
    req0_b = 1; we0_b = 0; addr0_b = 7'h00;
    for (int n = 1; n <= 9; n++) begin
      step();
      if (busy_b) busy_cnt++;
      if (ack_b != 2'b00 && ack_n == 0) begin
        ack_n = n; ack_val = ack_b; rd_seen = rdata_b; req0_b = 0;
      end
    end
    chk("lat_ack_edge", 32'(ack_n), 32'd5);
    chk("lat_busy_cycles", 32'(busy_cnt), 32'd5);
    chk("lat_ack_val", 32'(ack_val), 32'h1);
    chk("lat_rdata", 32'(rd_seen), 32'hBEEF);

    // Early drop of Req0 during ACCESS
    req0 = 1; we0 = 0; addr0 = 7'h10;
    step();
    chk("ed_gnt", 32'(gnt), 32'h1);
    req0 = 0;
    step(); step();
    chk("ed_ack", 32'(ack), 32'h1);
    chk("ed_rdata", 32'(rdata), 32'h1234);
    step();
    chk("ed_idle_busy", 32'(busy), 32'h0);
    step(); step();
    chk("ed_no_regrant", 32'(gnt), 32'h0);
    chk("ed_no_busy", 32'(busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
